// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg -- shared memory-map constants for the MMIO timer:
// register word offsets inside the 32-byte window, CTRL/STATUS bit
// positions and a byte-lane merge helper used by the register writes.
package mmio_timer_pkg;

  // Byte offsets of the registers inside the window
  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_COUNT    = 5'h08;
  localparam logic [4:0] OFF_COMPARE  = 5'h0C;
  localparam logic [4:0] OFF_PRESCALE = 5'h10;

  // CTRL bit positions
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  // STATUS bit positions
  localparam int STATUS_MATCH = 0;

  // Word index decoded from memAddr[4:2]; indices 5..7 are reserved
  typedef enum logic [2:0] {
    REG_CTRL     = OFF_CTRL[4:2],
    REG_STATUS   = OFF_STATUS[4:2],
    REG_COUNT    = OFF_COUNT[4:2],
    REG_COMPARE  = OFF_COMPARE[4:2],
    REG_PRESCALE = OFF_PRESCALE[4:2]
  } regIdx_t;

  // Replace only the byte lanes enabled in mask, keep the others
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  mask);
    logic [31:0] result;
    result = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        result[8*i +: 8] = newVal[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// timer_prescaler -- divides the timer clock enable: counts up while en is
// high, and when the count equals limit it returns to 0 and raises tick for
// that cycle. A limit of 0 therefore ticks on every enabled cycle. While en
// is low the count is held so the division phase resumes where it stopped.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] limit,
  output logic        tick
);

  logic [15:0] preCount;

  assign tick = en && (preCount == limit);

  // Advance the divider on enabled cycles, restarting from 0 after a tick
  always_ff @(posedge clk) begin
    if (reset) begin
      preCount <= 16'd0;
    end else if (en) begin
      if (preCount == limit) begin
        preCount <= 16'd0;
      end else begin
        preCount <= preCount + 16'd1;
      end
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer -- memory-mapped 32-bit timer with compare match, optional
// auto-reload and a level interrupt. Registers: CTRL, STATUS (W1C MATCH),
// COUNT, COMPARE, PRESCALE in a 32-byte window at BASE_ADDR.
// Build option: define MMIO_TIMER_PRESCALER_EN to include the PRESCALE
// register and the timer_prescaler divider; without it the counter ticks
// on every cycle that EN is set and PRESCALE reads as 0.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWriteData,
  input  logic        memWr,
  input  logic [3:0]  wrMask,
  output logic [31:0] memReadData,
  output logic        sel,
  output logic        irq
);

  logic [2:0]  ctrlReg;
  logic        matchReg;
  logic [31:0] countReg;
  logic [31:0] compareReg;
  logic [31:0] prescaleRead;
  logic        tick;
  logic        countHit;
  logic [31:0] countNext;
  regIdx_t     regIdx;
  logic        busWrite;
  logic        unusedAddrBits;

  assign sel            = (memAddr[31:5] == BASE_ADDR[31:5]);
  assign regIdx         = regIdx_t'(memAddr[4:2]);
  assign busWrite       = memWr && sel;
  assign unusedAddrBits = ^memAddr[1:0];

  assign countHit  = (countReg == compareReg);
  assign countNext = (countHit && ctrlReg[CTRL_AR]) ? 32'd0 : countReg + 32'd1;

  assign irq = matchReg && ctrlReg[CTRL_IE];

`ifdef MMIO_TIMER_PRESCALER_EN
  logic [31:0] prescaleReg;
  logic        unusedPrescaleHigh;

  assign prescaleRead       = prescaleReg;
  assign unusedPrescaleHigh = ^prescaleReg[31:16];

  // PRESCALE register, byte-lane writable
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaleReg <= 32'd0;
    end else if (busWrite && regIdx == REG_PRESCALE) begin
      prescaleReg <= mergeBytes(prescaleReg, memWriteData, wrMask);
    end
  end

  timer_prescaler prescalerInst (
    .clk   (clk),
    .reset (reset),
    .en    (ctrlReg[CTRL_EN]),
    .limit (prescaleReg[15:0]),
    .tick  (tick)
  );
`else
  assign prescaleRead = 32'd0;
  assign tick         = ctrlReg[CTRL_EN];
`endif

  // CTRL and COMPARE registers; only byte lane 0 of CTRL holds state
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlReg    <= 3'd0;
      compareReg <= 32'd0;
    end else begin
      if (busWrite && regIdx == REG_CTRL && wrMask[0]) begin
        ctrlReg <= memWriteData[2:0];
      end
      if (busWrite && regIdx == REG_COMPARE) begin
        compareReg <= mergeBytes(compareReg, memWriteData, wrMask);
      end
    end
  end

  // COUNT: a CPU write wins over the tick-driven increment or reload
  always_ff @(posedge clk) begin
    if (reset) begin
      countReg <= 32'd0;
    end else if (busWrite && regIdx == REG_COUNT) begin
      countReg <= mergeBytes(countReg, memWriteData, wrMask);
    end else if (tick) begin
      countReg <= countNext;
    end
  end

  // MATCH flag: set on a compare hit, which wins over a same-cycle W1C
  always_ff @(posedge clk) begin
    if (reset) begin
      matchReg <= 1'b0;
    end else if (tick && countHit) begin
      matchReg <= 1'b1;
    end else if (busWrite && regIdx == REG_STATUS && wrMask[0] &&
                 memWriteData[STATUS_MATCH]) begin
      matchReg <= 1'b0;
    end
  end

  // Zero-wait-state read mux; reserved offsets and out-of-window read 0
  always_comb begin
    memReadData = 32'd0;
    if (sel) begin
      case (regIdx)
        REG_CTRL:     memReadData = {29'd0, ctrlReg};
        REG_STATUS:   memReadData[STATUS_MATCH] = matchReg;
        REG_COUNT:    memReadData = countReg;
        REG_COMPARE:  memReadData = compareReg;
        REG_PRESCALE: memReadData = prescaleRead;
        default:      memReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer -- self-checking bench for mmio_timer: a table of directed
// bus cycles with fixed expected values, hand sequences for the multi-cycle
// corner cases, then random bus traffic compared against a behavioural
// model of the register map. Works with or without MMIO_TIMER_PRESCALER_EN.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memWr;
  logic [3:0]  wrMask;
  logic [31:0] memReadData;
  logic        sel;
  logic        irq;

  int total;
  int bad;

  // Behavioural model state
  logic        mEn, mAr, mIe, mMatch;
  logic [31:0] mCount, mCompare, mPrescale;
  logic [15:0] mPre;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] expRead;
    logic        expSel;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .memWr        (memWr),
    .wrMask       (wrMask),
    .memReadData  (memReadData),
    .sel          (sel),
    .irq          (irq)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] laneMask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if ((a >> 5) != (BASE >> 5)) return 32'd0;
    case (a[4:2])
      3'd0: return {29'd0, mIe, mAr, mEn};
      3'd1: return {31'd0, mMatch};
      3'd2: return mCount;
      3'd3: return mCompare;
`ifdef MMIO_TIMER_PRESCALER_EN
      3'd4: return mPrescale;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the register map, evaluated from the held bus inputs
  task automatic modelStep();
    logic        doTick, setReq, clrReq, inWin;
    logic [31:0] nextCount, m;
    if (reset) begin
      mEn = 0; mAr = 0; mIe = 0; mMatch = 0;
      mCount = 0; mCompare = 0; mPrescale = 0; mPre = 0;
      return;
    end
    doTick = 0;
    if (mEn) begin
`ifdef MMIO_TIMER_PRESCALER_EN
      if (mPre == mPrescale[15:0]) begin
        doTick = 1;
        mPre = 0;
      end else begin
        mPre = mPre + 16'd1;
      end
`else
      doTick = 1;
`endif
    end
    setReq = doTick && (mCount == mCompare);
    nextCount = doTick ? (setReq && mAr ? 32'd0 : mCount + 32'd1) : mCount;
    inWin = (memAddr >> 5) == (BASE >> 5);
    clrReq = memWr && inWin && memAddr[4:2] == 3'd1 && wrMask[0] && memWriteData[0];
    m = laneMask(wrMask);
    if (memWr && inWin) begin
      case (memAddr[4:2])
        3'd0: if (wrMask[0]) begin
          mEn = memWriteData[0]; mAr = memWriteData[1]; mIe = memWriteData[2];
        end
        3'd2: nextCount = (mCount & ~m) | (memWriteData & m);
        3'd3: mCompare = (mCompare & ~m) | (memWriteData & m);
`ifdef MMIO_TIMER_PRESCALER_EN
        3'd4: mPrescale = (mPrescale & ~m) | (memWriteData & m);
`endif
        default: ;
      endcase
    end
    mMatch = setReq || (mMatch && !clrReq);
    mCount = nextCount;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic w, input logic [3:0] m, input logic r);
    memAddr = a;
    memWriteData = d;
    memWr = w;
    wrMask = m;
    reset = r;
    @(negedge clk);
  endtask

  task automatic endCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(a, d, 1'b1, 4'hF, 1'b0);
    endCycle();
  endtask

  task automatic readCheck(input string name, input logic [31:0] a,
                           input logic [31:0] exp);
    applyStimulus(a, 32'd0, 1'b0, 4'hF, 1'b0);
    checkOutput(name, memReadData, exp);
    endCycle();
  endtask

  task automatic addVec(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [3:0] m, input logic [31:0] er,
                        input logic es, input logic ei);
    vecs.push_back('{addr: a, data: d, wr: w, mask: m, expRead: er, expSel: es, expIrq: ei});
  endtask

  initial begin
    logic [31:0] expSeq[7];
    logic [31:0] expPrescale;
    total = 0;
    bad = 0;

    // Reset for two cycles
    applyStimulus(BASE, 32'd0, 1'b0, 4'hF, 1'b1);
    endCycle();
    applyStimulus(BASE, 32'd0, 1'b0, 4'hF, 1'b1);
    endCycle();

    // Directed table: read value shown is the pre-edge register contents
    addVec(BASE + 32'h00, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h04, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h0C, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h10, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h14, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h0C, 3, 1, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h00, 7, 1, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h1, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h2, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h3, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h0, 1, 1);
    addVec(BASE + 32'h00, 4, 1, 4'hF, 32'h7, 1, 1);
    addVec(BASE + 32'h04, 0, 0, 4'hF, 32'h1, 1, 1);
    addVec(BASE + 32'h04, 1, 1, 4'b1110, 32'h1, 1, 1);
    addVec(BASE + 32'h04, 0, 0, 4'hF, 32'h1, 1, 1);
    addVec(BASE + 32'h04, 1, 1, 4'b0001, 32'h1, 1, 1);
    addVec(BASE + 32'h04, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h2, 1, 0);
    addVec(BASE + 32'h0C, 0, 1, 4'hF, 32'h3, 1, 0);
    addVec(BASE + 32'h0C, 32'hAABBCCDD, 1, 4'b0010, 32'h0, 1, 0);
    addVec(BASE + 32'h0C, 0, 0, 4'hF, 32'h0000_CC00, 1, 0);
    addVec(BASE + 32'h08, 32'hFFFF_FFFE, 1, 4'hF, 32'h2, 1, 0);
    addVec(BASE + 32'h0C, 5, 1, 4'hF, 32'h0000_CC00, 1, 0);
    addVec(BASE + 32'h00, 1, 1, 4'hF, 32'h4, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'hFFFF_FFFE, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'hFFFF_FFFF, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h08, 0, 0, 4'hF, 32'h1, 1, 0);
    addVec(BASE + 32'h04, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h00, 0, 1, 4'hF, 32'h1, 1, 0);
    addVec(32'h0000_0010, 0, 0, 4'hF, 32'h0, 0, 0);
    addVec(BASE + 32'h20, 0, 0, 4'hF, 32'h0, 0, 0);
    addVec(BASE + 32'h0B, 0, 0, 4'hF, 32'h4, 1, 0);
    addVec(32'hFFFE_0008, 32'h55, 1, 4'hF, 32'h0, 0, 0);
    addVec(BASE + 32'h09, 0, 0, 4'hF, 32'h4, 1, 0);
    addVec(BASE + 32'h14, 32'hFFFF_FFFF, 1, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h14, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h1C, 0, 0, 4'hF, 32'h0, 1, 0);
    addVec(BASE + 32'h10, 0, 0, 4'hF, 32'h0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].mask, 1'b0);
      checkOutput($sformatf("vec%0d.read", i), memReadData, vecs[i].expRead);
      checkOutput($sformatf("vec%0d.sel", i), {31'd0, sel}, {31'd0, vecs[i].expSel});
      checkOutput($sformatf("vec%0d.irq", i), {31'd0, irq}, {31'd0, vecs[i].expIrq});
      endCycle();
    end

    // Prescaler division: PRESCALE=2 divides by three when present
`ifdef MMIO_TIMER_PRESCALER_EN
    expSeq = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
    expPrescale = 32'd2;
`else
    expSeq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    expPrescale = 32'd0;
`endif
    busWrite(BASE + 32'h08, 32'd0);
    busWrite(BASE + 32'h10, 32'd2);
    busWrite(BASE + 32'h00, 32'd1);
    for (int i = 0; i < 7; i++) begin
      readCheck($sformatf("prescale.count%0d", i), BASE + 32'h08, expSeq[i]);
    end
    busWrite(BASE + 32'h00, 32'd0);
    readCheck("prescale.reg", BASE + 32'h10, expPrescale);

    // Reset wins over a same-cycle COUNT write
    applyStimulus(BASE + 32'h08, 32'h1234, 1'b1, 4'hF, 1'b1);
    endCycle();
    readCheck("rst.count", BASE + 32'h08, 32'd0);
    readCheck("rst.prescale", BASE + 32'h10, 32'd0);

    // MATCH set wins over a same-cycle W1C; AR=0 keeps counting past COMPARE
    busWrite(BASE + 32'h08, 32'd10);
    busWrite(BASE + 32'h0C, 32'd10);
    busWrite(BASE + 32'h00, 32'd5);
    applyStimulus(BASE + 32'h04, 32'd1, 1'b1, 4'b0001, 1'b0);
    checkOutput("prio.statusBefore", memReadData, 32'd0);
    endCycle();
    applyStimulus(BASE + 32'h04, 32'd0, 1'b0, 4'hF, 1'b0);
    checkOutput("prio.matchKept", memReadData, 32'd1);
    checkOutput("prio.irq", {31'd0, irq}, 32'd1);
    endCycle();
    readCheck("prio.countNoReload", BASE + 32'h08, 32'd12);

    // COUNT write wins over a same-cycle increment
    busWrite(BASE + 32'h08, 32'd100);
    readCheck("prio.countWrite", BASE + 32'h08, 32'd100);
    busWrite(BASE + 32'h00, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a, d;
      logic        w, r;
      logic [3:0]  m;
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 9) begin
        a = BASE | ($urandom & 32'h1F);
      end else begin
        a = $urandom;
      end
      w = $urandom_range(0, 1);
      m = 4'($urandom);
      case (a[4:2])
        3'd2, 3'd3: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
        3'd4:       d = 32'($urandom_range(0, 3));
        default:    d = $urandom;
      endcase
      applyStimulus(a, d, w, m, r);
      checkOutput($sformatf("rand%0d.read", i), memReadData, modelRead(a));
      checkOutput($sformatf("rand%0d.sel", i), {31'd0, sel},
                  {31'd0, ((a >> 5) == (BASE >> 5))});
      checkOutput($sformatf("rand%0d.irq", i), {31'd0, irq}, {31'd0, mMatch && mIe});
      endCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, base byte address of the 32-byte register window.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port memAddr  input  32  data-bus byte address from the CPU.
REQ-005 SHALL have port memWriteData  input  32  data-bus write data.
REQ-006 SHALL have port memWr  input  1  data-bus write enable.
REQ-007 SHALL have port wrMask  input  4  byte-lane write mask; bit i enables byte i.
REQ-008 SHALL have port memReadData  output  32  read data for the addressed register.
REQ-009 SHALL have port sel  output  1  high when memAddr falls in the window; drives the top-level read-data mux.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 SHALL assert sel combinationally when memAddr[31:5] == BASE_ADDR[31:5]; memAddr[1:0] ignored.
REQ-012 SHALL decode word offsets: 0x00 CTRL, 0x04 STATUS, 0x08 COUNT, 0x0C COMPARE, 0x10 PRESCALE; 0x14-0x1C reserved, read 0, writes ignored.
REQ-013 SHALL provide memReadData combinationally from the registered state, same cycle as memAddr (zero wait states); 0 when sel low.
REQ-014 SHALL perform writes at the clk edge when memWr and sel are high, per byte lane under wrMask; unmasked bytes keep their value.
REQ-015 CTRL bits: [0] EN counter enable, [1] AR auto-reload, [2] IE interrupt enable; bits [31:3] read 0.
REQ-016 STATUS bit [0] MATCH; writing 1 to a lane-enabled bit 0 clears it, writing 0 has no effect.
REQ-017 SHALL advance the prescaler each cycle EN=1; on prescaler == PRESCALE[15:0] it SHALL reset to 0 and emit a one-cycle tick; PRESCALE=0 gives a tick every cycle.
REQ-018 On tick, if COUNT == COMPARE, SHALL set MATCH and load COUNT with 0 when AR=1 or COUNT+1 when AR=0; otherwise COUNT+1.
REQ-019 COUNT SHALL wrap 32'hFFFF_FFFF -> 0 with no flag.
REQ-020 A CPU write to COUNT SHALL take priority over a same-cycle increment or reload.
REQ-021 A MATCH set SHALL take priority over a same-cycle W1C clear.
REQ-022 Clearing EN SHALL freeze COUNT and hold the prescaler at its current value; setting EN resumes from there.
REQ-023 irq SHALL equal MATCH AND IE, registered-state only (no combinational path from bus inputs).

Reset
REQ-024 On reset SHALL clear CTRL, STATUS, COUNT, COMPARE, PRESCALE and the prescaler to 0; irq=0 the following cycle.
REQ-025 Reset SHALL override any same-cycle bus write or tick.

Configuration
REQ-026 With MMIO_TIMER_PRESCALER_EN defined, the PRESCALE register and prescaler SHALL exist as specified.
REQ-027 Without MMIO_TIMER_PRESCALER_EN, tick SHALL equal EN every cycle, PRESCALE SHALL read 0, and writes to it SHALL be ignored.

Structure
REQ-028 Register offsets and CTRL/STATUS bit positions SHALL reside in the shared constants header, next to the existing memory-map constants.
REQ-029 The prescaler SHALL be a sub-module timer_prescaler (inputs clk, reset, en, limit; output tick), instantiated only under MMIO_TIMER_PRESCALER_EN.

Verification
REQ-030 Reset then read all five offsets -> every memReadData 0, irq 0.
REQ-031 Write COMPARE=3, CTRL=0x7 (PRESCALE 0) -> COUNT 0,1,2,3 on successive cycles, MATCH=1 and irq=1 after the fourth tick, COUNT back to 0.
REQ-032 Write COUNT=32'hFFFF_FFFE, COMPARE=5, CTRL=0x1 -> COUNT FFFF_FFFF, 0, 1; MATCH stays 0.
REQ-033 With MATCH set, write STATUS=1 with wrMask=4'b0001 -> MATCH 0, irq 0; repeat with wrMask=4'b1110 -> MATCH stays 1.
REQ-034 Write COMPARE with wrMask=4'b0010, data 32'hAABBCCDD, over prior 0 -> COMPARE reads 32'h0000_CC00.
REQ-035 With MMIO_TIMER_PRESCALER_EN, PRESCALE=2, CTRL=0x1 -> COUNT increments every third cycle; without the macro, same writes -> COUNT increments every cycle and PRESCALE reads 0.
